// File: rtl/memtest_pkg.sv
// =============================================================================
// Module      : memtest_pkg
// Description : Shared FSM states, mode encodings and LFSR constants for the
//               Avalon-MM memory tester.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_NOP   = 2'b00;
    localparam logic [1:0] MODE_FILL  = 2'b01;
    localparam logic [1:0] MODE_CHECK = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    // Galois form of x^32+x^22+x^2+x+1, shifting towards bit 0
    localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/memtest_patgen.sv
// =============================================================================
// Module      : memtest_patgen
// Description : Test pattern word generator: load a seed, step on advance.
//               MEMTEST_LFSR_EN selects the LFSR pattern instead of seed+i.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module memtest_patgen
    import memtest_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [DATA_W-1:0] i_seed,
    output logic [DATA_W-1:0] o_word
);

    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_init;
    logic [DATA_W-1:0] w_next;

`ifdef MEMTEST_LFSR_EN
    // An all-zero state would lock the LFSR, so a zero seed is substituted
    assign w_init = (i_seed == '0) ? DATA_W'(ZERO_SEED_SUB) : i_seed;

    generate
        if (DATA_W > 32) begin : g_lfsr_wide
            assign w_next = {r_word[DATA_W-1:32], lfsr_step(r_word[31:0])};
        end else if (DATA_W == 32) begin : g_lfsr_exact
            assign w_next = lfsr_step(r_word);
        end else begin : g_lfsr_narrow
            assign w_next = DATA_W'(lfsr_step(32'(r_word)));
        end
    endgenerate
`else
    assign w_init = i_seed;
    assign w_next = r_word + DATA_W'(1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= w_init;
        end else if (i_advance) begin
            r_word <= w_next;
        end
    end

    assign o_word = r_word;

endmodule

`default_nettype wire

// File: rtl/avmm_mem_tester.sv
// =============================================================================
// Module      : avmm_mem_tester
// Description : Avalon-MM master that fills a memory window with a pattern and
//               reads it back with pipelined reads. Optional: MEMTEST_LFSR_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module avmm_mem_tester
    import memtest_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int ERR_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    state_t            r_state;
    logic              r_do_check;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [ADDR_W-1:0] r_resp_cnt;
    logic [OUT_W-1:0]  r_outstanding;

    logic              w_start;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_rdv;
    logic              w_last_issue;
    logic              w_mismatch;
    logic [OUT_W-1:0]  w_out_next;
    logic [DATA_W-1:0] w_exp_word;

    assign w_start      = start && (r_state == ST_IDLE);
    assign w_wr_acc     = m_write && !m_waitrequest;
    assign w_rd_acc     = m_read && !m_waitrequest;
    // Responses only count while reads can be pending; strays are dropped
    assign w_rdv        = m_readdatavalid
                          && ((r_state == ST_CHECK) || (r_state == ST_DRAIN))
                          && (r_outstanding != '0);
    assign w_last_issue = (r_issue_cnt == (r_len - CNT_W'(1)));
    assign w_out_next   = r_outstanding + OUT_W'(w_rd_acc) - OUT_W'(w_rdv);
    assign w_mismatch   = w_rdv && (m_readdata != w_exp_word);

    memtest_patgen #(
        .DATA_W    (DATA_W)
    ) u_issue_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_start),
        .i_advance (w_wr_acc),
        .i_seed    (seed),
        .o_word    (m_writedata)
    );

    memtest_patgen #(
        .DATA_W    (DATA_W)
    ) u_expect_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_start),
        .i_advance (w_rdv),
        .i_seed    (seed),
        .o_word    (w_exp_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_do_check     <= 1'b0;
            r_base         <= '0;
            r_len          <= '0;
            r_issue_cnt    <= '0;
            r_resp_cnt     <= '0;
            r_outstanding  <= '0;
            m_address      <= '0;
            m_write        <= 1'b0;
            m_read         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b1;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done          <= 1'b0;
            r_outstanding <= w_out_next;

            if (w_wr_acc || w_rd_acc) begin
                m_address <= m_address + ADDR_W'(1);
            end

            if (w_rdv) begin
                r_resp_cnt <= r_resp_cnt + ADDR_W'(1);
            end

            // err_count never returns to zero within a run, so zero marks the first miss
            if (w_mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (err_count == '0) begin
                    first_err_addr <= r_base + r_resp_cnt;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_do_check     <= |(mode & MODE_CHECK);
                        r_base         <= base_addr;
                        r_len          <= length;
                        r_issue_cnt    <= '0;
                        r_resp_cnt     <= '0;
                        m_address      <= base_addr;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        busy           <= 1'b1;
                        if (length == '0) begin
                            r_state <= ST_DONE;
                        end else if (|(mode & MODE_FILL)) begin
                            r_state <= ST_FILL;
                            m_write <= 1'b1;
                        end else if (|(mode & MODE_CHECK)) begin
                            r_state <= ST_CHECK;
                            m_read  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_FILL: begin
                    if (w_wr_acc) begin
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                        if (w_last_issue) begin
                            m_write     <= 1'b0;
                            r_issue_cnt <= '0;
                            m_address   <= r_base;
                            if (r_do_check) begin
                                r_state <= ST_CHECK;
                                m_read  <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                end

                ST_CHECK: begin
                    if (w_rd_acc) begin
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                    end
                    if (w_rd_acc && w_last_issue) begin
                        m_read  <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        // Outstanding only falls while stalled, so a held read stays asserted
                        m_read <= (w_out_next < OUT_W'(MAX_OUT));
                    end
                end

                ST_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (err_count == '0);
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
